// File: rtl/aes_seq_ctrl.sv
// Byte-serial AES-128 encryption sequencer.
// Drives ShiftRows/MixColumns/converter controls, key-schedule strobes and output flags.
module aes_seq_ctrl #(
  parameter int OUT_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       pld,
  output logic [1:0] c3,
  output logic [7:0] mc_en,
  output logic       ks_load,
  output logic       ks_en,
  output logic [3:0] round,
  output logic       dout_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(OUT_LAT - 1);

  state_t             state;
  state_t             state_nxt;
  logic   [3:0]       byte_cnt;
  logic   [OUT_LAT-1:0] dv_pipe;
  logic               last_byte;
  logic               fin_rnd;
  logic               run_fin;

  assign last_byte  = (byte_cnt == 4'hf);
  assign fin_rnd    = (round == 4'd10);
  assign run_fin    = (state == RUN) && fin_rnd;
  assign dout_valid = dv_pipe[OUT_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= 4'h0;
      round    <= 4'h0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            err      <= 1'b0;
            byte_cnt <= 4'h0;
            round    <= 4'h0;
          end
        end
        LOAD: begin
          if (din_valid) begin
            byte_cnt <= byte_cnt + 4'h1;
            if (last_byte) round <= 4'd1;
          end else if (byte_cnt != 4'h0) begin
            // gap after byte 0: the datapath cannot stall, so abort
            err      <= 1'b1;
            byte_cnt <= 4'h0;
          end
        end
        RUN: begin
          byte_cnt <= byte_cnt + 4'h1;
          if (last_byte && !fin_rnd) round <= round + 4'h1;
        end
        FLUSH: begin
          byte_cnt <= byte_cnt + 4'h1;
          if (byte_cnt == FLUSH_LAST) begin
            byte_cnt <= 4'h0;
            round    <= 4'h0;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  // dout_valid follows the final round by OUT_LAT clocks
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_pipe <= '0;
    end else begin
      dv_pipe[0] <= run_fin;
      for (int i = 1; i < OUT_LAT; i++) dv_pipe[i] <= dv_pipe[i-1];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        if (din_valid && last_byte) state_nxt = RUN;
        else if (!din_valid && byte_cnt != 4'h0) state_nxt = IDLE;
      end
      RUN:   if (last_byte && fin_rnd) state_nxt = FLUSH;
      FLUSH: if (byte_cnt == FLUSH_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    pld       = 1'b0;
    c3        = 2'b00;
    mc_en     = 8'h00;
    ks_load   = 1'b0;
    ks_en     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      LOAD: begin
        din_ready = 1'b1;
        ks_en     = din_valid;
        ks_load   = din_valid && (byte_cnt == 4'h0);
      end
      RUN: begin
        ks_en = 1'b1;
        c3    = byte_cnt[1:0];
        if (!fin_rnd) begin
          mc_en = {4'h0, 4'b0001 << byte_cnt[1:0]};
          pld   = &byte_cnt[1:0];
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
